// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
// ALU opcodes, ID/EX and EX/MEM bundle layouts, multiplier FSM states.
package exec_pkg;

  localparam int DATA_W    = 32;
  localparam int IDX_W     = 4;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);
  localparam int BUNDLE_W  = 149;
  localparam int EXMEM_W   = 72;

  localparam int OFF_IMMSRC = 148;
  localparam int OFF_BRANCH = 147;
  localparam int OFF_MEMWR  = 146;
  localparam int OFF_MEM2RG = 145;
  localparam int OFF_REGWR  = 144;
  localparam int OFF_ALUCTL = 140;
  localparam int OFF_RA     = 136;
  localparam int OFF_RD1    = 104;
  localparam int OFF_RB     = 100;
  localparam int OFF_RD2    = 68;
  localparam int OFF_RC     = 64;
  localparam int OFF_RD3    = 32;
  localparam int OFF_IMM    = 0;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_MUL   = 4'd8;
  localparam logic [3:0] ALU_PASSB = 4'd9;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mul_state_e;

  typedef struct packed {
    logic              imm_src;
    logic              branch_flag;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [3:0]        alu_ctl;
    logic [IDX_W-1:0]  ra;
    logic [DATA_W-1:0] rd1;
    logic [IDX_W-1:0]  rb;
    logic [DATA_W-1:0] rd2;
    logic [IDX_W-1:0]  rc;
    logic [DATA_W-1:0] rd3;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch_taken;
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch_flag;
    logic [IDX_W-1:0]  rc;
    logic [DATA_W-1:0] store_data;
  } mul_ctl_t;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier, one partial product per enabled cycle.
// Only built when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module mul_iter
  import exec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = (state_q == S_RUN);
  assign done_o    = busy_o && (cnt_q == CNT_W'(MUL_STEPS-1));
  // last step's sum is the product; no extra cycle to latch it
  assign product_o = acc_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (done_o) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (en_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU and EX/MEM register.
// Define EXEC_MUL_EN to build the stalling iterative multiplier.
module execute_stage
  import exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BUNDLE_W-1:0] bufferIn,
  input  logic                WE,
  input  logic [IDX_W-1:0]    Rd,
  input  logic [DATA_W-1:0]   WD,
  output logic                regWriteOut,
  output logic                memToRegOut,
  output logic                memWriteOut,
  output logic                branchTakenOut,
  output logic [IDX_W-1:0]    RdOut,
  output logic [DATA_W-1:0]   aluResultOut,
  output logic [DATA_W-1:0]   storeDataOut,
  output logic                stall
);

  id_ex_t            id_ex;
  ex_mem_t           ex_mem_q, ex_mem_d, res;
  logic [DATA_W-1:0] op1, op2, fwd_b, fwd_c, alu_res;

  assign id_ex = id_ex_t'(bufferIn);

  // loads are not forwarded from EX/MEM: data not yet read
  function automatic logic [DATA_W-1:0] fwd(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] val
  );
    if (ex_mem_q.reg_write && !ex_mem_q.mem_to_reg
        && ex_mem_q.rd == idx)
      return ex_mem_q.result;
    else if (WE && Rd == idx)
      return WD;
    else
      return val;
  endfunction

  assign op1   = fwd(id_ex.ra, id_ex.rd1);
  assign fwd_b = fwd(id_ex.rb, id_ex.rd2);
  assign fwd_c = fwd(id_ex.rc, id_ex.rd3);
  assign op2   = id_ex.imm_src ? id_ex.imm : fwd_b;

  always_comb begin
    alu_res = '0;
    case (id_ex.alu_ctl)
      ALU_ADD:   alu_res = op1 + op2;
      ALU_SUB:   alu_res = op1 - op2;
      ALU_AND:   alu_res = op1 & op2;
      ALU_OR:    alu_res = op1 | op2;
      ALU_XOR:   alu_res = op1 ^ op2;
      ALU_SLL:   alu_res = op1 << op2[4:0];
      ALU_SRL:   alu_res = op1 >> op2[4:0];
      ALU_SRA:   alu_res = $signed(op1) >>> op2[4:0];
      ALU_PASSB: alu_res = op2;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    res              = '0;
    res.reg_write    = id_ex.reg_write;
    res.mem_to_reg   = id_ex.mem_to_reg;
    res.mem_write    = id_ex.mem_write;
    res.branch_taken = id_ex.branch_flag && (alu_res == '0);
    res.rd           = id_ex.rc;
    res.result       = alu_res;
    res.store_data   = fwd_c;
  end

`ifdef EXEC_MUL_EN
  logic              is_mul, mul_start;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;
  mul_ctl_t          cap_q, cap_d;

  assign is_mul    = (id_ex.alu_ctl == ALU_MUL);
  assign mul_start = rst && en && !mul_busy && is_mul;
  assign stall     = rst && (mul_busy ? !mul_done : is_mul);

  mul_iter u_mul (
    .clk_i     (clk),
    .rst_ni    (rst),
    .en_i      (en),
    .start_i   (mul_start),
    .a_i       (op1),
    .b_i       (op2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    ex_mem_d = res;
    cap_d    = cap_q;
    if (mul_done) begin
      ex_mem_d.reg_write    = cap_q.reg_write;
      ex_mem_d.mem_to_reg   = cap_q.mem_to_reg;
      ex_mem_d.mem_write    = cap_q.mem_write;
      ex_mem_d.branch_taken = cap_q.branch_flag
                              && (mul_prod == '0);
      ex_mem_d.rd           = cap_q.rc;
      ex_mem_d.result       = mul_prod;
      ex_mem_d.store_data   = cap_q.store_data;
    end else if (stall) begin
      // bubble: kill flags, keep data
      ex_mem_d              = ex_mem_q;
      ex_mem_d.reg_write    = 1'b0;
      ex_mem_d.mem_to_reg   = 1'b0;
      ex_mem_d.mem_write    = 1'b0;
      ex_mem_d.branch_taken = 1'b0;
    end
    if (mul_start) begin
      cap_d.reg_write   = id_ex.reg_write;
      cap_d.mem_to_reg  = id_ex.mem_to_reg;
      cap_d.mem_write   = id_ex.mem_write;
      cap_d.branch_flag = id_ex.branch_flag;
      cap_d.rc          = id_ex.rc;
      cap_d.store_data  = fwd_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_mem_q <= '0;
      cap_q    <= '0;
    end else if (en) begin
      ex_mem_q <= ex_mem_d;
      cap_q    <= cap_d;
    end
  end
`else
  assign stall    = 1'b0;
  assign ex_mem_d = res;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_mem_q <= '0;
    end else if (en) begin
      ex_mem_q <= ex_mem_d;
    end
  end
`endif

  assign regWriteOut    = ex_mem_q.reg_write;
  assign memToRegOut    = ex_mem_q.mem_to_reg;
  assign memWriteOut    = ex_mem_q.mem_write;
  assign branchTakenOut = ex_mem_q.branch_taken;
  assign RdOut          = ex_mem_q.rd;
  assign aluResultOut   = ex_mem_q.result;
  assign storeDataOut   = ex_mem_q.store_data;

endmodule
